// File: rtl/rect_compositor.sv
// rect_compositor: VGA timing plus N_RECT prioritised rectangles committed atomically at vblank start.
// Optional GFX_BOUNCE_EN: per-rectangle velocity applied at each commit, bouncing off the active area.
module rect_compositor #(
  parameter int N_RECT = 4,
  parameter int COLOR_W = 4,
  parameter int PIX_DIV = 4,
  parameter int H_ACTIVE = 640, H_FP = 16, H_SYNC = 96, H_BP = 48,
  parameter int V_ACTIVE = 480, V_FP = 10, V_SYNC = 2, V_BP = 33,
  parameter logic [3*COLOR_W-1:0] BG_COLOR = '0,
  localparam int IW = N_RECT > 1 ? $clog2(N_RECT) : 1,
  localparam int CW = 3*COLOR_W
)(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               wr_valid_i,
  output logic               wr_ready_o,
  input  logic [IW-1:0]      wr_idx_i,
  input  logic               wr_en_i,
  input  logic [9:0]         wr_x0_i,
  input  logic [9:0]         wr_x1_i,
  input  logic [9:0]         wr_y0_i,
  input  logic [9:0]         wr_y1_i,
  input  logic [CW-1:0]      wr_color_i,
`ifdef GFX_BOUNCE_EN
  input  logic signed [3:0]  wr_dx_i,
  input  logic signed [3:0]  wr_dy_i,
`endif
  output logic               hsync_o,
  output logic               vsync_o,
  output logic [COLOR_W-1:0] vga_r_o,
  output logic [COLOR_W-1:0] vga_g_o,
  output logic [COLOR_W-1:0] vga_b_o,
  output logic               frame_start_o
);
  localparam int DW = PIX_DIV > 1 ? $clog2(PIX_DIV) : 1;
  localparam logic [DW-1:0] D_LAST = DW'(PIX_DIV - 1);
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HA = 10'(H_ACTIVE), VA = 10'(V_ACTIVE), V_CM = 10'(V_ACTIVE - 1);
  localparam logic [9:0] HS0 = 10'(H_ACTIVE + H_FP), HS1 = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS0 = 10'(V_ACTIVE + V_FP), VS1 = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef struct packed {
    logic             en;
    logic [9:0]       x0, x1, y0, y1;
    logic [CW-1:0]    col;
`ifdef GFX_BOUNCE_EN
    logic signed [3:0] dx, dy;
`endif
  } rect_t;

  logic [DW-1:0] div_q, div_d;
  logic [9:0] h_q, h_d, v_q, v_d;
  logic pix_stb, commit, wr_fire;
  rect_t sh_q [N_RECT];
  rect_t lv_q [N_RECT];
  rect_t lv_d [N_RECT];
  rect_t wr_rect;
  logic [N_RECT-1:0] dirty_q, hit_q, hit_d;
  logic act_q, hs1_q, vs1_q, hs_q, vs_q;
  logic [CW-1:0] col_q, col_d;

  assign pix_stb = div_q == D_LAST;
  assign commit = pix_stb && h_q == H_LAST && v_q == V_CM;
  assign wr_ready_o = !commit;
  assign frame_start_o = commit;
  assign wr_fire = wr_valid_i && wr_ready_o;
`ifdef GFX_BOUNCE_EN
  assign wr_rect = {wr_en_i, wr_x0_i, wr_x1_i, wr_y0_i, wr_y1_i, wr_color_i, wr_dx_i, wr_dy_i};

  function automatic logic off_edge(input logic [9:0] a0, a1, input logic signed [3:0] d, input logic [9:0] lim);
    logic signed [11:0] n0, n1;
    n0 = $signed({2'b0, a0}) + 12'(d);
    n1 = $signed({2'b0, a1}) + 12'(d);
    return n0 < 0 || n1 > $signed({2'b0, lim});
  endfunction
`else
  assign wr_rect = {wr_en_i, wr_x0_i, wr_x1_i, wr_y0_i, wr_y1_i, wr_color_i};
`endif

  always_comb begin
    div_d = pix_stb ? '0 : div_q + 1'b1;
    h_d = pix_stb ? (h_q == H_LAST ? '0 : h_q + 1'b1) : h_q;
    v_d = (pix_stb && h_q == H_LAST) ? (v_q == V_LAST ? '0 : v_q + 1'b1) : v_q;
  end

  // Next live table at commit: dirty entries take the shadow, the rest keep (or move)
  always_comb
    for (int i = 0; i < N_RECT; i++) begin
      lv_d[i] = dirty_q[i] ? sh_q[i] : lv_q[i];
`ifdef GFX_BOUNCE_EN
      if (!dirty_q[i] && lv_q[i].en) begin
        if (off_edge(lv_q[i].x0, lv_q[i].x1, lv_q[i].dx, HA)) lv_d[i].dx = -lv_q[i].dx;
        else begin
          lv_d[i].x0 = lv_q[i].x0 + 10'(lv_q[i].dx);
          lv_d[i].x1 = lv_q[i].x1 + 10'(lv_q[i].dx);
        end
        if (off_edge(lv_q[i].y0, lv_q[i].y1, lv_q[i].dy, VA)) lv_d[i].dy = -lv_q[i].dy;
        else begin
          lv_d[i].y0 = lv_q[i].y0 + 10'(lv_q[i].dy);
          lv_d[i].y1 = lv_q[i].y1 + 10'(lv_q[i].dy);
        end
      end
`endif
    end

  always_comb
    for (int i = 0; i < N_RECT; i++)
      hit_d[i] = lv_q[i].en && h_q >= lv_q[i].x0 && h_q < lv_q[i].x1 && v_q >= lv_q[i].y0 && v_q < lv_q[i].y1;

  always_comb begin
    col_d = BG_COLOR;
    for (int i = N_RECT - 1; i >= 0; i--) if (hit_q[i]) col_d = lv_q[i].col;
    if (!act_q) col_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      div_q <= '0;
      h_q <= '0;
      v_q <= '0;
    end else begin
      div_q <= div_d;
      h_q <= h_d;
      v_q <= v_d;
    end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      for (int i = 0; i < N_RECT; i++) begin
        sh_q[i] <= '0;
        lv_q[i] <= '0;
      end
      dirty_q <= '0;
    end else
      for (int i = 0; i < N_RECT; i++) begin
        if (wr_fire && int'(wr_idx_i) == i) begin
          sh_q[i] <= wr_rect;
          dirty_q[i] <= 1'b1;
        end
        if (commit) begin
          lv_q[i] <= lv_d[i];
          dirty_q[i] <= 1'b0;
        end
      end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      hit_q <= '0;
      act_q <= 1'b0;
      hs1_q <= 1'b1;
      vs1_q <= 1'b1;
      col_q <= '0;
      hs_q <= 1'b1;
      vs_q <= 1'b1;
    end else if (pix_stb) begin
      hit_q <= hit_d;
      act_q <= h_q < HA && v_q < VA;
      hs1_q <= !(h_q >= HS0 && h_q < HS1);
      vs1_q <= !(v_q >= VS0 && v_q < VS1);
      col_q <= col_d;
      hs_q <= hs1_q;
      vs_q <= vs1_q;
    end

  assign hsync_o = hs_q;
  assign vsync_o = vs_q;
  assign vga_r_o = col_q[CW-1 -: COLOR_W];
  assign vga_g_o = col_q[2*COLOR_W-1 -: COLOR_W];
  assign vga_b_o = col_q[COLOR_W-1:0];
endmodule

// File: tb/tb_rect_compositor.sv
// tb_rect_compositor: clock-accurate reference model of timing, shadow/commit and pixel priority.
module tb_rect_compositor;
  localparam int N = 3, PD = 2;
  localparam int HA = 16, HFP = 2, HSW = 3, HBP = 3, VA = 12, VFP = 1, VSW = 2, VBP = 2;
  localparam int HT = HA + HFP + HSW + HBP, VT = VA + VFP + VSW + VBP, FR = HT * VT * PD;
  localparam logic [11:0] BG = 12'h35A;

  typedef struct {bit en; int x0, x1, y0, y1; logic [11:0] col;} rect_t;
  typedef struct {logic [11:0] c; logic hs, vs;} px_t;

  logic clk = 0, rst_n = 0, wr_valid = 0, wr_en = 0;
  logic [1:0] wr_idx = 0;
  logic [9:0] wr_x0 = 0, wr_x1 = 0, wr_y0 = 0, wr_y1 = 0;
  logic [11:0] wr_color = 0;
  logic wr_ready, hsync, vsync, frame_start;
  logic [3:0] vga_r, vga_g, vga_b;

  rect_t sh[N], lv[N];
  bit dirty[N];
  px_t pipe, out_e;
  int cnt, vectors, errors;
  bit acc;

  rect_compositor #(
    .N_RECT(N), .COLOR_W(4), .PIX_DIV(PD),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP), .BG_COLOR(BG)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
    .wr_idx_i(wr_idx), .wr_en_i(wr_en), .wr_x0_i(wr_x0), .wr_x1_i(wr_x1),
    .wr_y0_i(wr_y0), .wr_y1_i(wr_y1), .wr_color_i(wr_color),
`ifdef GFX_BOUNCE_EN
    .wr_dx_i(4'sd0), .wr_dy_i(4'sd0),
`endif
    .hsync_o(hsync), .vsync_o(vsync), .vga_r_o(vga_r), .vga_g_o(vga_g), .vga_b_o(vga_b),
    .frame_start_o(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0t observed %h expected %h", tag, $time, obs, exp);
    end
  endtask

  function automatic px_t pix(int h, int v);
    px_t r;
    r.hs = !(h >= HA + HFP && h < HA + HFP + HSW);
    r.vs = !(v >= VA + VFP && v < VA + VFP + VSW);
    r.c = 12'h000;
    if (h < HA && v < VA) begin
      r.c = BG;
      for (int i = 0; i < N; i++)
        if (lv[i].en && h >= lv[i].x0 && h < lv[i].x1 && v >= lv[i].y0 && v < lv[i].y1) begin
          r.c = lv[i].col;
          break;
        end
    end
    return r;
  endfunction

  task automatic model_reset();
    cnt = 0;
    for (int i = 0; i < N; i++) begin
      sh[i] = '{0, 0, 0, 0, 0, 12'h0};
      lv[i] = '{0, 0, 0, 0, 0, 12'h0};
      dirty[i] = 0;
    end
    pipe = '{12'h0, 1'b1, 1'b1};
    out_e = pipe;
  endtask

  task automatic check_reset();
    chk("rst_hsync", hsync, 1);
    chk("rst_vsync", vsync, 1);
    chk("rst_rgb", {vga_r, vga_g, vga_b}, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_wr_ready", wr_ready, 1);
  endtask

  // One clock: handshake checks before the edge, model update on it, output checks after it
  task automatic tick();
    bit stb, cm;
    int s, h, v;
    cnt++;
    stb = (cnt % PD) == 0;
    s = cnt / PD;
    h = (s - 1) % HT;
    v = ((s - 1) / HT) % VT;
    cm = stb && h == HT - 1 && v == VA - 1;
    chk("wr_ready", wr_ready, !cm);
    chk("frame_start", frame_start, cm);
    acc = wr_valid && !cm;
    @(posedge clk);
    if (acc && int'(wr_idx) < N) begin
      sh[wr_idx] = '{wr_en, int'(wr_x0), int'(wr_x1), int'(wr_y0), int'(wr_y1), wr_color};
      dirty[wr_idx] = 1;
    end
    if (stb) begin
      out_e = pipe;
      pipe = pix(h, v);
    end
    if (cm)
      for (int i = 0; i < N; i++) begin
        if (dirty[i]) lv[i] = sh[i];
        dirty[i] = 0;
      end
    #1;
    chk("rgb", {vga_r, vga_g, vga_b}, out_e.c);
    chk("hsync", hsync, out_e.hs);
    chk("vsync", vsync, out_e.vs);
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_wr(int idx, bit en, int x0, int x1, int y0, int y1, logic [11:0] c);
    wr_idx = 2'(idx);
    wr_en = en;
    wr_x0 = 10'(x0);
    wr_x1 = 10'(x1);
    wr_y0 = 10'(y0);
    wr_y1 = 10'(y1);
    wr_color = c;
  endtask

  task automatic wr(int idx, bit en, int x0, int x1, int y0, int y1, logic [11:0] c);
    int n = 0;
    set_wr(idx, en, x0, x1, y0, y1, c);
    wr_valid = 1;
    do begin
      tick();
      n++;
    end while (!acc && n < 8);
    wr_valid = 0;
  endtask

  task automatic rand_wr();
    set_wr($urandom_range(0, 3), 1'($urandom_range(0, 3) != 0), $urandom_range(0, 20),
           $urandom_range(0, 26), $urandom_range(0, 14), $urandom_range(0, 18), 12'($urandom));
  endtask

  initial begin
    model_reset();
    #23;
    check_reset();
    @(posedge clk);
    #1 rst_n = 1;
    run(2 * FR);
    wr(0, 1, 3, 7, 1, 5, 12'hF00);
    wr(1, 1, 5, 9, 3, 7, 12'h0F0);
    run(2 * FR);
    run(FR / 3);
    wr(2, 1, 0, 16, 11, 12, 12'h00F);
    wr(2, 1, 15, 16, 0, 12, 12'h0FF);
    wr(1, 1, 6, 6, 0, 12, 12'hFFF);
    wr(3, 1, 0, 16, 0, 12, 12'hF0F);
    wr(0, 1, 0, 16, 4, 4, 12'hABC);
    run(2 * FR);
    wr_valid = 1;
    for (int i = 0; i < 2 * FR; i++) begin
      rand_wr();
      tick();
    end
    for (int i = 0; i < 12 * FR; i++) begin
      wr_valid = $urandom_range(0, 5) == 0;
      rand_wr();
      tick();
    end
    wr_valid = 0;
    wr(0, 1, 2, 12, 2, 10, 12'h777);
    run(FR + FR / 2);
    rst_n = 0;
    #2;
    check_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_reset();
    model_reset();
    rst_n = 1;
    run(2 * FR);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/rect_compositor.md
# rect_compositor

Parametrised VGA rectangle compositor: generates VGA timing from the board clock and draws up to N_RECT programmable, coloured, prioritised rectangles over a background colour. Rectangles are programmed through a valid/ready register-write port into shadow registers, which are committed atomically at the start of vertical blanking so frames never tear. It sits between the system clock and the VGA connector as the next-generation display engine, replacing fixed-geometry drawing.

## Interface
- N_RECT, 4: number of rectangles, 1..16
- COLOR_W, 4: bits per colour channel
- PIX_DIV, 4: system clocks per pixel, ≥2
- H_ACTIVE/H_FP/H_SYNC/H_BP, 640/16/96/48: horizontal timing, in pixels
- V_ACTIVE/V_FP/V_SYNC/V_BP, 480/10/2/33: vertical timing, in lines
- BG_COLOR, 0: background {R,G,B}, 3*COLOR_W bits

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- wr_valid  in  1  rectangle write request
- wr_ready  out  1  write accepted when wr_valid & wr_ready
- wr_idx  in  IW=max(1,$clog2(N_RECT))  target rectangle
- wr_en  in  1  rectangle visible
- wr_x0, wr_x1  in  10  x bounds, half-open [x0,x1)
- wr_y0, wr_y1  in  10  y bounds, half-open [y0,y1)
- wr_color  in  3*COLOR_W  {R,G,B}
- hsync, vsync  out  1  active-low syncs
- VGA_R, VGA_G, VGA_B  out  COLOR_W  each  pixel colour
- frame_start  out  1  one-clk pulse on commit

## Operation
- Pixel strobe: divider counts 0..PIX_DIV-1. pix_stb is high for the single clk where the count equals PIX_DIV-1. The first strobe occurs on the PIX_DIV-th clk after reset release.
- Counters h (0..H_total-1) and v (0..V_total-1) advance on pix_stb only. h wraps to 0 and increments v. v wraps at V_total.
- Raw signals:
  - hs_raw is low for H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC.
  - vs_raw is low for the analogous v range.
  - active = (h < H_ACTIVE) & (v < V_ACTIVE).
- Write port:
  - An accepted write stores {wr_en, bounds, colour} into shadow[wr_idx] and sets dirty[wr_idx].
  - A write with wr_idx ≥ N_RECT is accepted and discarded.
- Commit point: the clk where pix_stb is high and the counters are about to become h=0, v=V_ACTIVE.
  - During that clk wr_ready=0, so no write can coincide with a commit.
  - Every dirty entry is copied shadow→live and all dirty bits clear.
  - frame_start pulses for exactly that clk.
- Hit test: rect i hits when live_en[i] & x0≤h<x1 & y0≤v<y1. x1≤x0 or y1≤y0 gives an empty rectangle; this is legal.
- Priority: lowest hitting index wins, otherwise BG_COLOR. Outside the active area the output colour is 0.

## Timing
- Reset values:
  - divider, h, v, dirty, live_en, shadow_en: 0
  - hsync, vsync: 1
  - VGA_R/G/B: 0
  - frame_start: 0
  - wr_ready: 1
- Pipeline is two pixel strobes:
  - Stage 1 registers the per-rect hit vector, active flag, and raw syncs.
  - Stage 2 registers the priority-selected colour and the syncs.
  - Colour and syncs for a pixel (h,v) therefore appear together, 2 strobes after the counters hold (h,v).
- Outputs change only on pix_stb clks, except frame_start and wr_ready.
- A write's effect is first visible on the frame beginning at v=0 after the next commit.
- Reset asserted mid-frame clears everything immediately. Live rectangles are not retained.

## Configuration
- GFX_BOUNCE_EN defined: adds ports wr_dx and wr_dy (in, 4, signed per-frame velocity), stored with each write.
  - At commit, each non-dirty live rectangle with live_en=1 moves by its velocity, one axis at a time.
  - If x0+dx<0 or x1+dx>H_ACTIVE, dx negates and x does not move that frame. y is handled the same way with dy and V_ACTIVE.
  - Dirty rectangles take the shadow values and do not move that frame.
- GFX_BOUNCE_EN undefined: no velocity ports. Live rectangles change only via commit.

## Test plan
- Reset then free-run with defaults -> hsync period 800×PIX_DIV clks, low for 96 pixels; vsync period 525 lines, low for 2 lines; frame_start once per frame; RGB 0 everywhere.
- Write rect0 [120,280)×[40,200) red, rect1 [200,360)×[120,280) green -> after commit: pixel (250,150) red (priority); (300,250) green; (279,40) red; (280,40) background; (639,479) background.
- Hold wr_valid continuously across the commit -> wr_ready low exactly on the frame_start clk; every write lands in either the current or the next frame, never lost or split.
- Write during frame k -> colour unchanged for the remainder of frame k, updated from frame k+1 v=0; a second write to the same idx before commit: last value wins.
- Empty rect (x1=x0) and wr_idx=N_RECT write -> no pixel changes, wr_ready behaviour unchanged.
- GFX_BOUNCE_EN: rect [630,639)×[0,10), dx=+4 -> next commit: dx becomes −4, x unchanged; following commit: x0=626.
